mult_share_sched: RTL



---
 rtl/mult_share_pkg.sv | 30 +++
 rtl/mult_share_sched_rr_arbiter.sv | 44 ++++
 rtl/mult_share_sched.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mult_share_pkg.sv
// mult_share_pkg
//   Shared types and constants for the multiplier-sharing scheduler.
//   t_req_id  : requester index, sized for the largest supported requester count
//   t_mul_tag : in-flight tag travelling alongside the multiplier pipeline
//   next_ptr  : round-robin pointer advance with wrap
package mult_share_pkg;

   localparam int MAX_NUM_REQ         = 8;
   localparam int REQ_ID_W            = (MAX_NUM_REQ > 1) ? $clog2(MAX_NUM_REQ) : 1;
   localparam int DEFAULT_MUL_LATENCY = 2;

   typedef logic [REQ_ID_W-1:0] t_req_id;

   typedef struct packed {
      logic    valid;
      t_req_id id;
   } t_mul_tag;

   // Pointer to the slot after k, wrapping back to 0 past the last requester.
   function automatic t_req_id next_ptr(input t_req_id k, input int num_req);
      t_req_id nxt;
      if (int'(k) >= (num_req - 32'sd1)) begin
         nxt = {REQ_ID_W{1'b0}};
      end else begin
         nxt = k + t_req_id'(1'b1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Picks the first asserted request at or
//   after rr_ptr, wrapping modulo NUM_REQ. The pointer register is owned by
//   the caller.
//   req         in  NUM_REQ : request vector
//   rr_ptr      in          : search start index
//   grant       out NUM_REQ : one-hot grant (zero when no request)
//   grant_id    out         : encoded index of the granted requester
//   grant_valid out         : a grant was made
module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] req,
   input  t_req_id            rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output t_req_id            grant_id,
   output logic               grant_valid
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] idx_s;

   // Walk the requests starting at rr_ptr; the first hit wins.
   always_comb begin
      grant       = {NUM_REQ{1'b0}};
      grant_id    = {REQ_ID_W{1'b0}};
      grant_valid = 1'b0;
      idx_s       = {IDX_W{1'b0}};
      for (int off = 0; off < NUM_REQ; off++) begin
         idx_s = IDX_W'((int'(rr_ptr) + off) % NUM_REQ);
         if (!grant_valid && req[idx_s]) begin
            grant[idx_s] = 1'b1;
            grant_id     = t_req_id'(idx_s);
            grant_valid  = 1'b1;
         end else begin
            // an earlier slot already won, or this slot is idle
         end
      end
   end

endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched
//   Time-shares one external fixed-latency pipelined multiplier among NUM_REQ
//   requesters. Operands are accepted round-robin (one per cycle at most), a
//   tag pipeline matched to MUL_LATENCY tracks which requester owns each
//   product, and each product lands in that requester's result register.
//   Each requester may have only one operation outstanding.
//   clk, reset         : clock, asynchronous active-high reset
//   req_valid/ready    : per-requester operand handshake (ready is one-hot)
//   req_a, req_b       : packed operands, slice i*DATA_LEN +: DATA_LEN
//   rsp_valid/ready    : per-requester result handshake
//   rsp_data           : packed result registers, sliced like the operands
//   mul_a, mul_b       : registered operands to the multiplier (0 when idle)
//   mul_result         : multiplier product, MUL_LATENCY cycles after mul_a/b
//   busy               : any requester has an operation outstanding
//   ops_issued         : wrapping count of accepted requests
module mult_share_sched
   import mult_share_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_LEN    = 32,
   parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
   input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
   output logic [NUM_REQ-1:0]           rsp_valid,
   input  logic [NUM_REQ-1:0]           rsp_ready,
   output logic [NUM_REQ*DATA_LEN-1:0]  rsp_data,
   output logic [DATA_LEN-1:0]          mul_a,
   output logic [DATA_LEN-1:0]          mul_b,
   input  logic [DATA_LEN-1:0]          mul_result,
   output logic                         busy,
   output logic [31:0]                  ops_issued
);

   logic [NUM_REQ-1:0]          outstanding_r;
   t_req_id                     rr_ptr_r;
   t_mul_tag                    tag_r [0:MUL_LATENCY];
   logic [NUM_REQ-1:0]          rsp_valid_r;
   logic [NUM_REQ*DATA_LEN-1:0] rsp_data_r;
   logic [DATA_LEN-1:0]         mul_a_r;
   logic [DATA_LEN-1:0]         mul_b_r;
   logic [31:0]                 ops_issued_r;

   logic [NUM_REQ-1:0]          eligible_s;
   logic [NUM_REQ-1:0]          grant_s;
   t_req_id                     grant_id_s;
   logic                        grant_valid_s;
   logic                        accept_s;
   logic [NUM_REQ-1:0]          accept_vec_s;
   logic [NUM_REQ-1:0]          hs_vec_s;
   logic [NUM_REQ-1:0]          land_vec_s;
   logic [DATA_LEN-1:0]         a_sel_s;
   logic [DATA_LEN-1:0]         b_sel_s;

   assign eligible_s = req_valid & ~outstanding_r;
   assign hs_vec_s   = rsp_valid_r & rsp_ready;

   rr_arbiter #(
      .NUM_REQ     (NUM_REQ)
   ) u_arb (
      .req         (eligible_s),
      .rr_ptr      (rr_ptr_r),
      .grant       (grant_s),
      .grant_id    (grant_id_s),
      .grant_valid (grant_valid_s)
   );

   // Grant is masked while reset is high so ready reads 0 even if requesters
   // keep valid asserted through reset.
   always_comb begin
      req_ready    = {NUM_REQ{1'b0}};
      accept_vec_s = {NUM_REQ{1'b0}};
      accept_s     = 1'b0;
      if (reset) begin
         req_ready = {NUM_REQ{1'b0}};
      end else begin
         req_ready    = grant_s;
         accept_vec_s = req_valid & grant_s;
         accept_s     = grant_valid_s;
      end
   end

   // Operand mux driven by the one-hot grant.
   always_comb begin
      a_sel_s = {DATA_LEN{1'b0}};
      b_sel_s = {DATA_LEN{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_s[i]) begin
            a_sel_s = req_a[i*DATA_LEN +: DATA_LEN];
            b_sel_s = req_b[i*DATA_LEN +: DATA_LEN];
         end else begin
            // not the granted requester
         end
      end
   end

   // Decode the owner of the product emerging from the multiplier this cycle.
   always_comb begin
      land_vec_s = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         land_vec_s[i] = tag_r[MUL_LATENCY].valid &&
                         (tag_r[MUL_LATENCY].id == t_req_id'(i));
      end
   end

   // Outstanding flags: set on accept, cleared on the response handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         outstanding_r <= {NUM_REQ{1'b0}};
      end else begin
         outstanding_r <= (outstanding_r | accept_vec_s) & ~hs_vec_s;
      end
   end

   // Round-robin pointer moves past the winner only when a grant happens.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_r <= {REQ_ID_W{1'b0}};
      end else if (accept_s) begin
         rr_ptr_r <= next_ptr(grant_id_s, NUM_REQ);
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

   // Registered multiplier operands, zeroed on idle cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mul_a_r <= {DATA_LEN{1'b0}};
         mul_b_r <= {DATA_LEN{1'b0}};
      end else if (accept_s) begin
         mul_a_r <= a_sel_s;
         mul_b_r <= b_sel_s;
      end else begin
         mul_a_r <= {DATA_LEN{1'b0}};
         mul_b_r <= {DATA_LEN{1'b0}};
      end
   end

   // Tag pipeline: stage 0 aligns with mul_a/mul_b, stage MUL_LATENCY with
   // mul_result. It never stalls, matching the multiplier.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s <= MUL_LATENCY; s++) begin
            tag_r[s] <= {1'b0, {REQ_ID_W{1'b0}}};
         end
      end else begin
         tag_r[0] <= {accept_s, grant_id_s};
         for (int s = 1; s <= MUL_LATENCY; s++) begin
            tag_r[s] <= tag_r[s-1];
         end
      end
   end

   // Result registers. A landing and a handshake never hit the same requester
   // in one cycle because a requester cannot reissue while outstanding.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_r <= {NUM_REQ{1'b0}};
         rsp_data_r  <= {(NUM_REQ*DATA_LEN){1'b0}};
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (land_vec_s[i]) begin
               rsp_valid_r[i]                      <= 1'b1;
               rsp_data_r[i*DATA_LEN +: DATA_LEN]  <= mul_result;
            end else if (hs_vec_s[i]) begin
               rsp_valid_r[i] <= 1'b0;
            end else begin
               rsp_valid_r[i] <= rsp_valid_r[i];
            end
         end
      end
   end

   // Accepted-request counter, free-running wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ops_issued_r <= 32'd0;
      end else if (accept_s) begin
         ops_issued_r <= ops_issued_r + 32'd1;
      end else begin
         ops_issued_r <= ops_issued_r;
      end
   end

   assign rsp_valid  = rsp_valid_r;
   assign rsp_data   = rsp_data_r;
   assign mul_a      = mul_a_r;
   assign mul_b      = mul_b_r;
   assign busy       = |outstanding_r;
   assign ops_issued = ops_issued_r;

endmodule
